// File: rtl/floo_vc_rx_buffer.sv
// Credit-based NoC link receiver: demultiplexes incoming flits into per-VC FIFOs,
// presents each VC as a valid/ready stream and returns one credit per popped flit.
module floo_vc_rx_buffer #(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned Depth           = 4,
  parameter type         flit_t          = logic,
  parameter int unsigned VcIdWidth       = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         valid_i,
  input  logic [VcIdWidth-1:0]         vc_id_i,
  input  flit_t                        data_i,
  output logic [NumVirtChannels-1:0]   credit_o,
  output logic [NumVirtChannels-1:0]   valid_o,
  input  logic [NumVirtChannels-1:0]   ready_i,
  output flit_t [NumVirtChannels-1:0]  data_o,
  output logic                         err_o,
  output logic [VcIdWidth-1:0]         err_vc_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  ptr_t [NumVirtChannels-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t [NumVirtChannels-1:0] count_q, count_d;
  logic [NumVirtChannels-1:0] push, pop, hit, full, credit_q;
  logic                       vc_ok, viol;
  logic [VcIdWidth-1:0]       vc_sel;
  logic                       err_q, err_d;
  logic [VcIdWidth-1:0]       err_vc_q, err_vc_d;
  flit_t                      mem_q [NumVirtChannels][Depth];

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      valid_o[v] = (count_q[v] != '0);
      data_o[v]  = mem_q[v][rptr_q[v]];
    end
  end

  always_comb begin
    vc_sel   = (NumVirtChannels == 1) ? '0 : vc_id_i;
    vc_ok    = (NumVirtChannels == 1) || (32'(vc_id_i) < NumVirtChannels);
    viol     = valid_i && !vc_ok;
    push     = '0;
    pop      = '0;
    hit      = '0;
    full     = '0;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    err_d    = err_q;
    err_vc_d = err_vc_q;
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      pop[v]  = valid_o[v] && ready_i[v];
      hit[v]  = valid_i && vc_ok && (32'(vc_sel) == v);
      full[v] = (count_q[v] == cnt_t'(Depth));
      // A pop in the same cycle frees the slot the incoming flit needs.
      push[v] = hit[v] && (!full[v] || pop[v]);
      viol    = viol || (hit[v] && full[v] && !pop[v]);
      if (push[v]) wptr_d[v] = ptr_inc(wptr_q[v]);
      if (pop[v])  rptr_d[v] = ptr_inc(rptr_q[v]);
      if (push[v] && !pop[v])      count_d[v] = count_q[v] + cnt_t'(1);
      else if (pop[v] && !push[v]) count_d[v] = count_q[v] - cnt_t'(1);
    end
    if (viol && !err_q) begin
      err_d    = 1'b1;
      err_vc_d = vc_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      credit_q <= '0;
      err_q    <= 1'b0;
      err_vc_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      credit_q <= pop;
      err_q    <= err_d;
      err_vc_q <= err_vc_d;
    end
  end

  // Storage carries no reset; occupancy counts alone define validity.
  always_ff @(posedge clk_i) begin
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      if (push[v]) mem_q[v][wptr_q[v]] <= data_i;
    end
  end

  assign credit_o = credit_q;
  assign err_o    = err_q;
  assign err_vc_o = err_vc_q;

endmodule

// File: tb/tb_floo_vc_rx_buffer.sv
// Scoreboard bench for floo_vc_rx_buffer: directed scenarios then credit-respecting random traffic.
module tb_floo_vc_rx_buffer;

  localparam int N = 2;
  localparam int D = 4;
  typedef logic [7:0] flit_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          vc_id_i = 1'b0;
  flit_t         data_i = '0;
  logic [N-1:0]  credit_o;
  logic [N-1:0]  valid_o;
  logic [N-1:0]  ready_i = '0;
  flit_t [N-1:0] data_o;
  logic          err_o;
  logic          err_vc_o;

  floo_vc_rx_buffer #(
    .NumVirtChannels(N),
    .Depth(D),
    .flit_t(flit_t)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .valid_i(valid_i),
    .vc_id_i(vc_id_i),
    .data_i(data_i),
    .credit_o(credit_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o(data_o),
    .err_o(err_o),
    .err_vc_o(err_vc_o)
  );

  always #5 clk = ~clk;

  // Reference model: per-VC ordered queues of accepted flits plus abstract occupancy.
  flit_t        sbq [N][$];
  int           occ [N];
  int           outst [N];
  int           scred [N];
  logic [N-1:0] popm = '0;
  logic [N-1:0] m_credit = '0;
  logic         m_err = 1'b0;
  logic         m_err_vc = 1'b0;
  int           mc;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < N; v++) begin
        sbq[v].delete();
        occ[v]   = 0;
        outst[v] = 0;
        scred[v] = D;
      end
      m_credit = '0;
      m_err    = 1'b0;
      m_err_vc = 1'b0;
    end else begin
      for (int v = 0; v < N; v++) begin
        scred[v] += int'(credit_o[v]);
        popm[v]  = ready_i[v] && (occ[v] > 0);
        if (popm[v]) occ[v]--;
      end
      if (valid_i) begin
        mc = int'(vc_id_i);
        scred[mc]--;
        if (occ[mc] == D) begin
          if (!m_err) m_err_vc = vc_id_i;
          m_err = 1'b1;
        end else begin
          sbq[mc].push_back(data_i);
          occ[mc]++;
          outst[mc]++;
        end
      end
      m_credit = popm;
    end
  end

  always @(negedge clk) begin
    for (int v = 0; v < N; v++) begin
      chk($sformatf("valid_o[%0d]", v), 32'(valid_o[v]), 32'(occ[v] > 0));
      if (occ[v] > 0 && sbq[v].size() > 0) begin
        chk($sformatf("data_o[%0d]", v), 32'(data_o[v]), 32'(sbq[v][0]));
        if (ready_i[v]) void'(sbq[v].pop_front());
      end
      chk($sformatf("credit_o[%0d]", v), 32'(credit_o[v]), 32'(m_credit[v]));
      if (credit_o[v] === 1'b1) outst[v]--;
      chk($sformatf("credit_invariant[%0d]", v), 32'(outst[v] <= D), 32'(1));
    end
    chk("err_o", 32'(err_o), 32'(m_err));
    if (m_err) chk("err_vc_o", 32'(err_vc_o), 32'(m_err_vc));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int vc, input flit_t d);
    valid_i = 1'b1;
    vc_id_i = 1'(vc);
    data_i  = d;
    step();
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // single flit
    ready_i = 2'b11;
    send(1, 8'hA5);
    idle(4);

    // fill and drain VC0
    ready_i = 2'b00;
    for (int i = 1; i <= 4; i++) send(0, 8'(i));
    idle(3);
    ready_i = 2'b01;
    idle(6);

    // VC independence: VC0 full and stalled while VC1 streams
    ready_i = 2'b00;
    for (int i = 0; i < 4; i++) send(0, 8'(8'h10 + i));
    ready_i = 2'b10;
    for (int i = 0; i < 8; i++) send(1, 8'(8'h30 + i));
    idle(3);

    // full VC0 with simultaneous pop accepts the push
    ready_i = 2'b01;
    send(0, 8'h05);
    idle(6);

    // overflow on VC1, then a later overflow on VC0
    ready_i = 2'b00;
    for (int i = 0; i < 4; i++) send(1, 8'(8'h50 + i));
    send(1, 8'hEE);
    idle(2);
    for (int i = 0; i < 4; i++) send(0, 8'(8'h60 + i));
    send(0, 8'hBB);
    idle(2);
    ready_i = 2'b11;
    idle(6);

    // reset mid-traffic
    ready_i = 2'b00;
    for (int i = 0; i < 3; i++) send(0, 8'(8'h70 + i));
    do_reset();
    idle(1);
    ready_i = 2'b01;
    send(0, 8'h77);
    idle(3);

    // randomized traffic with a credit-respecting sender
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        do_reset();
        continue;
      end
      ready_i = 2'($urandom);
      valid_i = 1'b0;
      if ($urandom_range(3) != 0) begin
        int vc;
        vc = int'($urandom_range(N - 1));
        if (scred[vc] > 0) begin
          valid_i = 1'b1;
          vc_id_i = 1'(vc);
          data_i  = 8'($urandom);
        end
      end
      step();
    end
    valid_i = 1'b0;
    ready_i = 2'b11;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/floo_vc_rx_buffer.md
Name: floo_vc_rx_buffer

Overview:
- Receiving end of a credit-based physical NoC link. One flit per cycle arrives on a shared physical channel, tagged with its virtual channel (VC) id.
- Each flit is written into a per-VC FIFO. Each VC is presented downstream as an independent valid/ready stream.
- A one-cycle credit pulse is returned to the upstream sender for every flit that leaves a FIFO.
- Sits at a router input port, or at the far end of a link pipeline, wherever upstream flow control is by credits rather than ready.

Parameters:
- NumVirtChannels, 2, number of VCs on the link. Must be ≥1.
- Depth, 4, FIFO entries per VC. Must be ≥1. This is also the initial credit count the upstream sender holds per VC.
- flit_t, logic, flit payload type.
- VcIdWidth, (NumVirtChannels>1 ? $clog2(NumVirtChannels) : 1), width of the VC id. Derived; not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  flit present on the physical link this cycle. There is no ready; the sender guarantees credit.
- vc_id_i  in  VcIdWidth  target VC of the incoming flit. Ignored when NumVirtChannels==1.
- data_i  in  $bits(flit_t)  incoming flit
- credit_o  out  NumVirtChannels  one-cycle credit-return pulse per VC
- valid_o  out  NumVirtChannels  per-VC head flit valid
- ready_i  in  NumVirtChannels  per-VC downstream ready
- data_o  out  NumVirtChannels x $bits(flit_t)  per-VC head flit
- err_o  out  1  sticky credit-protocol violation flag
- err_vc_o  out  VcIdWidth  VC of the first violation

Behaviour:
- Clocking and reset:
  - Single clock, all state updates on the rising edge of clk_i. Reset is synchronous and active-low.
  - While rst_ni=0 at an edge: all FIFOs are emptied and all pointers and counts cleared. credit_o=0, valid_o=0, err_o=0, err_vc_o=0. data_o is don't-care.
  - Reset mid-operation discards all buffered flits and returns no credits for them. The sender must reset its credit counters to Depth at the same time.
- Push:
  - When valid_i=1, the flit is written to FIFO[vc_id_i] at the edge.
  - vc_id_i ≥ NumVirtChannels is a violation: the flit is dropped, err_o is set, and err_vc_o captures vc_id_i truncated to VcIdWidth.
- Latency:
  - No fall-through. A flit pushed at edge t gives valid_o[v]=1 from cycle t+1.
  - Minimum input-to-output latency is 1 cycle.
- Pop:
  - A pop occurs on FIFO[v] when valid_o[v] && ready_i[v].
  - data_o[v] shows the FIFO head and stays stable while valid_o[v]=1 and ready_i[v]=0.
  - valid_o[v] does not depend combinationally on ready_i.
  - Each VC is independent; no head-of-line blocking between VCs.
- Per-VC occupancy count, width $clog2(Depth+1):
  - push only → +1
  - pop only → −1
  - push and pop in the same cycle → unchanged
  - Read and write pointers wrap modulo Depth; Depth need not be a power of two.
- Full boundary:
  - A push to a VC whose count==Depth with no pop in the same cycle is a credit violation.
  - The flit is dropped and the FIFO contents are unchanged. err_o is set.
  - err_vc_o records this VC only if err_o was previously 0; first error wins.
  - A push to a full VC that pops in the same cycle is legal and accepted.
- Empty boundary: valid_o[v]=0 when count==0. A push into an empty FIFO is visible the next cycle.
- Credits:
  - credit_o[v] is a registered pulse, asserted for exactly 1 cycle in the cycle after each pop on VC v.
  - Back-to-back pops give back-to-back credit pulses.
  - Dropped (violating) flits return no credit.
- err_o and err_vc_o are sticky until reset.
- Invariant (assertion in the bench): across all time, pushes accepted minus credits returned, per VC, never exceeds Depth.

Test Plan:
- Single flit: reset, then valid_i=1, vc_id_i=1, data_i=0xA5 for one cycle, ready_i=2'b11 → valid_o=2'b10 the next cycle with data_o[1]=0xA5; credit_o=2'b10 for exactly one cycle on the cycle after that; valid_o=0 afterwards.
- Fill and drain: Depth=4, ready_i[0]=0, push 0x1..0x4 to VC0 → valid_o[0] held, data_o[0]=0x1 stable. Then raise ready_i[0] → pops 0x1,0x2,0x3,0x4 in order on 4 consecutive cycles, and credit_o[0] pulses on 4 consecutive cycles, each one cycle later.
- VC independence: VC0 full and stalled (ready_i[0]=0), then stream 8 flits to VC1 with ready_i[1]=1 → all 8 emerge on VC1 in order with 8 credits on credit_o[1]; VC0 contents unchanged; err_o=0.
- Full with simultaneous pop: VC0 holds 4 flits, ready_i[0]=1, push 0x5 in the same cycle → accepted, count stays 4, err_o=0; 0x5 later emerges after 0x2..0x4.
- Violation: VC1 full, ready_i[1]=0, push 0xEE to VC1 → err_o=1 and err_vc_o=1 from the next cycle; 0xEE never appears on data_o; no credit returned. A later overflow on VC0 leaves err_vc_o=1.
- Reset mid-traffic: with 3 flits buffered on VC0, drive rst_ni=0 for one edge → next cycle valid_o=0, credit_o=0, err_o=0; a subsequent push 0x77 to VC0 emerges alone, one cycle later.
